// File: rtl/uart_baud_gen_frac.sv
// Fractional-N baud tick generator: rx enable at OVERSAMPLE x baud, tx enable at baud.
// Period length is int(divisor) plus the carry out of a running fraction accumulator.
module uart_baud_gen_frac #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_DEFAULT = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int FRAC_BITS    = 4,
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_DEFAULT  = int'((64'(CLK_FREQ) << FRAC_BITS) /
                                    (64'(BAUD_DEFAULT) * 64'(OVERSAMPLE)))
) (
  input  logic                           clk_50m,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           rx_resync,
  input  logic                           div_wr,
  input  logic [DIV_WIDTH+FRAC_BITS-1:0] div_in,
  output logic                           rxclk_en,
  output logic                           txclk_en,
  output logic [DIV_WIDTH+FRAC_BITS-1:0] div_cur,
  output logic                           div_pending
);

  localparam int DW  = DIV_WIDTH + FRAC_BITS;
  localparam int OSW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [DW-1:0]        DIV_RST = DW'(DIV_DEFAULT);
  localparam logic [DIV_WIDTH-1:0] MIN_INT = DIV_WIDTH'(2);
  localparam logic [DW-1:0]        MIN_DIV = {MIN_INT, {FRAC_BITS{1'b0}}};
  localparam logic [DIV_WIDTH:0]   CNT_ONE = (DIV_WIDTH+1)'(1);
  localparam logic [OSW-1:0]       OS_ONE  = OSW'(1);
  localparam logic [OSW-1:0]       OS_LAST = OSW'(OVERSAMPLE - 1);

  logic [DIV_WIDTH:0]   r_cnt;
  logic [FRAC_BITS-1:0] r_acc;
  logic [OSW-1:0]       r_os;
  logic [DW-1:0]        r_div_cur;
  logic [DW-1:0]        r_div_pend;
  logic                 r_pending;
  logic                 r_rxclk_en;
  logic                 r_txclk_en;

  logic [DIV_WIDTH-1:0] w_int;
  logic [FRAC_BITS:0]   w_frac_sum;
  logic [DIV_WIDTH:0]   w_plen;
  logic                 w_last;
  logic                 w_boundary;
  logic [DW-1:0]        w_div_clamped;

  // The carry is derived from the accumulator as it stood at the start of this
  // period; the accumulator only advances when the period ends.
  assign w_int      = r_div_cur[DW-1:FRAC_BITS];
  assign w_frac_sum = {1'b0, r_acc} + {1'b0, r_div_cur[FRAC_BITS-1:0]};
  assign w_plen     = {1'b0, w_int} + {{DIV_WIDTH{1'b0}}, w_frac_sum[FRAC_BITS]};
  // >= rather than == so a divisor shrunk while frozen cannot strand the counter.
  assign w_last     = (r_cnt >= (w_plen - CNT_ONE));
  assign w_boundary = enable & ~rx_resync & w_last;

  assign w_div_clamped = (div_in[DW-1:FRAC_BITS] < MIN_INT) ? MIN_DIV : div_in;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_os       <= '0;
      r_rxclk_en <= 1'b0;
      r_txclk_en <= 1'b0;
    end else begin
      r_rxclk_en <= w_boundary;
      r_txclk_en <= w_boundary & (r_os == OS_LAST);
      if (rx_resync) begin
        r_cnt <= '0;
        r_acc <= '0;
        r_os  <= '0;
      end else if (enable) begin
        if (w_last) begin
          r_cnt <= '0;
          r_acc <= w_frac_sum[FRAC_BITS-1:0];
          r_os  <= r_os + OS_ONE;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end
  end

  // A fresh write always re-arms the pending slot; otherwise a pending divisor
  // lands on a period boundary, or on the next edge when the generator is frozen.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      r_div_cur  <= DIV_RST;
      r_div_pend <= DIV_RST;
      r_pending  <= 1'b0;
    end else if (div_wr) begin
      r_div_pend <= w_div_clamped;
      r_pending  <= 1'b1;
    end else if (r_pending && (w_boundary || !enable)) begin
      r_div_cur <= r_div_pend;
      r_pending <= 1'b0;
    end
  end

  assign rxclk_en    = r_rxclk_en;
  assign txclk_en    = r_txclk_en;
  assign div_cur     = r_div_cur;
  assign div_pending = r_pending;

endmodule
